// File: rtl/cla8_adder.sv
// rtl/cla8_adder.sv - 8-bit two-level carry-lookahead adder with registered {cout, sum}
// Optional carry-in port enabled by defining CLA8_CIN_EN.

module cla8_group4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c,
    output logic [3:0] o_c,
    output logic       o_gg,
    output logic       o_gp
);
    // Every carry is a flat sum of products from the group carry-in, so no bit waits on its neighbour.
    assign o_c[0] = i_c;
    assign o_c[1] = i_g[0] | (i_p[0] & i_c);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c);
    assign o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                  | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_gp   = &i_p;
endmodule

module cla8_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
`ifdef CLA8_CIN_EN
    ,
    input  logic       cin
`endif
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_c;
    logic       w_c0;
    logic       w_c4;
    logic       w_cout;
    logic       w_gg0;
    logic       w_gp0;
    logic       w_gg1;
    logic       w_gp1;
    logic [7:0] r_sum;
    logic       r_cout;

`ifdef CLA8_CIN_EN
    assign w_c0 = cin;
`else
    assign w_c0 = 1'b0;
`endif

    assign w_g = a & b;
    assign w_p = a ^ b;

    cla8_group4 u_lo (
        .i_g  (w_g[3:0]),
        .i_p  (w_p[3:0]),
        .i_c  (w_c0),
        .o_c  (w_c[3:0]),
        .o_gg (w_gg0),
        .o_gp (w_gp0)
    );

    cla8_group4 u_hi (
        .i_g  (w_g[7:4]),
        .i_p  (w_p[7:4]),
        .i_c  (w_c4),
        .o_c  (w_c[7:4]),
        .o_gg (w_gg1),
        .o_gp (w_gp1)
    );

    // Second-level lookahead: upper carry-in and carry-out straight from group terms.
    assign w_c4   = w_gg0 | (w_gp0 & w_c0);
    assign w_cout = w_gg1 | (w_gp1 & w_gg0) | (w_gp1 & w_gp0 & w_c0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 8'h00;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_p ^ w_c;
            r_cout <= w_cout;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_cla8_adder.sv
// tb/tb_cla8_adder.sv - self-checking bench for cla8_adder against an arithmetic reference
module tb_cla8_adder;
    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
`ifdef CLA8_CIN_EN
    logic       cin;
`endif
    int checks;
    int errors;

    cla8_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA8_CIN_EN
        ,
        .cin   (cin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operand set between edges, then check {cout,sum} just after the next edge.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input string tag);
        logic [8:0] exp;
        @(negedge clk);
        a = ta;
        b = tb;
`ifdef CLA8_CIN_EN
        cin = tc;
        exp = {1'b0, ta} + {1'b0, tb} + {8'h00, tc};
`else
        exp = {1'b0, ta} + {1'b0, tb};
`endif
        @(posedge clk);
        #1;
        check(tag, {cout, sum}, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a = 8'h00;
        b = 8'h00;
`ifdef CLA8_CIN_EN
        cin = 1'b0;
`endif
        #3;
        check("reset_initial", {cout, sum}, 9'h000);
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        check("reset_holds_over_edge", {cout, sum}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        step(8'hFA, 8'hF0, 1'b0, "dir_fa_f0");
        check("dir_fa_f0_const", {cout, sum}, 9'h1EA);
        step(8'hFA, 8'hF1, 1'b0, "dir_fa_f1");
        step(8'h38, 8'h90, 1'b0, "dir_38_90");
        check("dir_38_90_const", {cout, sum}, 9'h0C8);
        step(8'hC2, 8'hB0, 1'b0, "dir_c2_b0");
        step(8'hFF, 8'h01, 1'b0, "full_prop_ff_01");
        check("full_prop_const", {cout, sum}, 9'h100);
        step(8'hFF, 8'hFF, 1'b0, "max_ff_ff");
        step(8'h00, 8'h00, 1'b0, "zero");
`ifdef CLA8_CIN_EN
        step(8'hFF, 8'h00, 1'b1, "cin_full_prop");
        check("cin_full_prop_const", {cout, sum}, 9'h100);
        step(8'hFF, 8'hFF, 1'b1, "cin_max");
`endif

        step(8'h55, 8'h2A, 1'b0, "pre_reset_nonzero");
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_immediate", {cout, sum}, 9'h000);
        a = 8'h01;
        b = 8'h02;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_first_edge", {cout, sum}, 9'h003);

        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), "random_sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
